ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_stream_gen.sv | 177 +++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670 sensor emulator: drives PCLK/VSYNC/HREF/D with VGA YUV422 framing and
// one of four deterministic luma test patterns.
module ov7670_stream_gen #(
  parameter int unsigned ACT_W       = 640,
  parameter int unsigned ACT_H       = 480,
  parameter int unsigned H_BLANK     = 288,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter logic [7:0]  SOLID_Y     = 8'h80
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  mode_i,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  d_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned LineTp = 2 * ACT_W + H_BLANK;
  localparam int unsigned HW     = $clog2(LineTp);
  localparam int unsigned LW     = 16;
  localparam int unsigned BarPix = ACT_W / 8;
  localparam int unsigned BW     = (BarPix > 1) ? $clog2(BarPix) : 1;

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e          state_q, state_d;
  logic            pclk_q;
  logic [HW-1:0]   h_q, h_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]      fcnt_lat_q, fcnt_lat_d;
  logic [2:0]      bar_q, bar_d;
  logic [BW-1:0]   bar_pix_q, bar_pix_d;

  logic tick, line_end, active_byte;

  // Tick is the clk edge where pclk falls; everything else moves only then.
  assign tick        = pclk_q;
  assign line_end    = (h_q == HW'(LineTp - 1));
  assign active_byte = (state_q == StActive) && (h_q < HW'(2 * ACT_W));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pclk_q       <= 1'b0;
      state_q      <= StIdle;
      h_q          <= '0;
      line_q       <= '0;
      mode_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      fcnt_lat_q   <= '0;
      bar_q        <= '0;
      bar_pix_q    <= '0;
    end else begin
      pclk_q       <= ~pclk_q;
      state_q      <= state_d;
      h_q          <= h_d;
      line_q       <= line_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      fcnt_lat_q   <= fcnt_lat_d;
      bar_q        <= bar_d;
      bar_pix_q    <= bar_pix_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    line_d       = line_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    fcnt_lat_d   = fcnt_lat_q;
    bar_d        = bar_q;
    bar_pix_d    = bar_pix_q;
    if (tick) begin
      if (state_q != StIdle) begin
        h_d = line_end ? '0 : h_q + 1'b1;
        if (line_end) line_d = line_q + 1'b1;
      end
      // Bar index advances after each chroma byte, every BarPix pixels.
      if (line_end || (state_q != StActive)) begin
        bar_d     = '0;
        bar_pix_d = '0;
      end else if (active_byte && h_q[0]) begin
        if (bar_pix_q == BW'(BarPix - 1)) begin
          bar_pix_d = '0;
          bar_d     = bar_q + 1'b1;
        end else begin
          bar_pix_d = bar_pix_q + 1'b1;
        end
      end
      case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_d    = StVsync;
            h_d        = '0;
            line_d     = '0;
            mode_d     = mode_i;
            busy_d     = 1'b1;
            fcnt_lat_d = frame_cnt_q[7:0];
          end
        end
        StVsync: begin
          if (line_end && (line_q == LW'(VSYNC_LINES - 1))) begin
            state_d = StVback;
            line_d  = '0;
          end
        end
        StVback: begin
          if (line_end && (line_q == LW'(V_BACK - 1))) begin
            state_d = StActive;
            line_d  = '0;
          end
        end
        StActive: begin
          if (line_end && (line_q == LW'(ACT_H - 1))) begin
            state_d = StVfront;
            line_d  = '0;
          end
        end
        StVfront: begin
          if (line_end && (line_q == LW'(V_FRONT - 1))) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            line_d       = '0;
            if (enable_i) begin
              state_d    = StVsync;
              mode_d     = mode_i;
              fcnt_lat_d = frame_cnt_d[7:0];
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  logic [7:0] y_byte;

  always_comb begin
    case (mode_q)
      2'd0:    y_byte = {bar_q, 5'b0};
      2'd1:    y_byte = 8'(h_q >> 1);
      2'd2:    y_byte = 8'(h_q >> 1) + 8'(line_q) + fcnt_lat_q;
      default: y_byte = SOLID_Y;
    endcase
    vsync_o = (state_q == StVsync);
    href_o  = active_byte;
    d_o     = 8'h00;
    if (active_byte) d_o = h_q[0] ? 8'h80 : y_byte;
  end

  assign pclk_o       = pclk_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: directed scenarios plus random enable/mode/reset
// traffic, every clk compared against a frame-position reference model.
module tb_ov7670_stream_gen;

  localparam int ACT_W    = 8;
  localparam int ACT_H    = 2;
  localparam int H_BLANK  = 4;
  localparam int VS       = 1;
  localparam int VB       = 1;
  localparam int VF       = 1;
  localparam int LINE_TP  = 2 * ACT_W + H_BLANK;
  localparam int FRAME_TP = LINE_TP * (VS + VB + ACT_H + VF);
  localparam logic [7:0] SOLID = 8'h80;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  mode;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  d;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ov7670_stream_gen #(
    .ACT_W(ACT_W), .ACT_H(ACT_H), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .SOLID_Y(SOLID)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
    .pclk_o(pclk), .vsync_o(vsync), .href_o(href), .d_o(d),
    .frame_done_o(frame_done), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       rst_s = 1'b1, en_s = 1'b0;
  logic [1:0] mode_s = '0;
  always @(posedge clk) begin
    rst_s  <= rst;
    en_s   <= enable;
    mode_s <= mode;
  end

  // Reference: pclk phase, running flag, and tick position p within the frame.
  bit          pclk_m, running, busy_m, fd_m;
  int          p;
  logic [15:0] cnt_m, base_m;
  logic [1:0]  mode_m;

  task automatic model_step();
    bit t;
    if (rst_s) begin
      pclk_m = 0; running = 0; p = 0; busy_m = 0; fd_m = 0; cnt_m = '0;
    end else begin
      t = pclk_m;
      pclk_m = !pclk_m;
      fd_m = 0;
      if (t) begin
        if (running) begin
          p++;
          if (p == FRAME_TP) begin
            fd_m = 1; cnt_m++; running = 0; busy_m = 0;
          end
        end
        if (!running && en_s) begin
          running = 1; busy_m = 1; p = 0; mode_m = mode_s; base_m = cnt_m;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int line_n, h, x, yl;
    bit act;
    logic [7:0] ed;
    line_n = p / LINE_TP;
    h      = p % LINE_TP;
    x      = h / 2;
    yl     = line_n - VS - VB;
    act    = running && line_n >= VS + VB && line_n < VS + VB + ACT_H && h < 2 * ACT_W;
    ed     = 8'h00;
    if (act) begin
      if (h % 2 == 1) ed = 8'h80;
      else case (mode_m)
        2'd0:    ed = 8'(((x * 8) / ACT_W) * 32);
        2'd1:    ed = 8'(x);
        2'd2:    ed = 8'(x + yl + int'(base_m));
        default: ed = SOLID;
      endcase
    end
    check_eq("pclk", 32'(pclk), 32'(pclk_m));
    check_eq("vsync", 32'(vsync), 32'(running && line_n < VS));
    check_eq("href", 32'(href), 32'(act));
    check_eq("d", 32'(d), 32'(ed));
    check_eq("frame_done", 32'(frame_done), 32'(fd_m));
    check_eq("busy", 32'(busy), 32'(busy_m));
    check_eq("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
      check_outputs();
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    if (frame_done !== 1'b1) check_eq("frame_done_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_href(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (href !== 1'b1 && n < budget);
    if (href !== 1'b1) check_eq("href_timeout", 32'(href), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0;
    idle(3);
    rst = 1'b0;
    idle(50);
    // Single frame per mode, enable dropped early so no back-to-back follows.
    mode = 2'd1; enable = 1'b1; idle(10); enable = 1'b0; wait_done(400); idle(20);
    mode = 2'd0; enable = 1'b1; idle(10); enable = 1'b0; wait_done(400); idle(20);
    // Three back-to-back ramp frames.
    mode = 2'd2; enable = 1'b1;
    wait_done(400); wait_done(400); enable = 1'b0; wait_done(400); idle(20);
    // Mid-frame mode change and disable only take effect after the frame.
    mode = 2'd3; enable = 1'b1; wait_href(400);
    mode = 2'd1; enable = 1'b0; wait_done(400); idle(30);
    // Reset during an active line, enable held.
    mode = 2'd1; enable = 1'b1; wait_href(400);
    idle(3);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(300);
    enable = 1'b0; wait_done(400); idle(10);
    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      enable = 1'($urandom_range(0, 3) != 0);
      mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end
      idle(int'($urandom_range(1, 150)));
    end
    enable = 1'b0;
    idle(450);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
